// File: rtl/fp_pkg.sv
// Shared floating-point types: default widths, operand classes, sqrt FSM states
// and the canonical quiet-NaN encoding.
package fp_pkg;

   localparam int FP_EXP_W = 8;
   localparam int FP_MAN_W = 23;

   typedef enum logic [2:0] {ZERO, DENORM, NORM, INF, QNAN, SNAN} fp_class_e;

   typedef enum logic [1:0] {IDLE, CALC, ROUND, DONE} sqrt_state_e;

   // {0, all-ones exponent, fraction MSB set}, zero-extended to 64 bits.
   function automatic logic [63:0] fp_qnan(input int exp_w, input int man_w);
      return (((64'd1 << exp_w) - 64'd1) << man_w) | (64'd1 << (man_w - 1));
   endfunction

endpackage

// File: rtl/fp_classify.sv
// Combinational IEEE-754 operand decode into class and sign; zero latency, no handshake.
module fp_classify
   import fp_pkg::*;
#(
   parameter int EXP_W = FP_EXP_W,
   parameter int MAN_W = FP_MAN_W
) (
   input  logic [EXP_W+MAN_W:0] i_a,
   output fp_class_e            o_cls,
   output logic                 o_sign
);

   logic [EXP_W-1:0] w_exp;
   logic [MAN_W-1:0] w_frac;

   assign w_exp  = i_a[MAN_W +: EXP_W];
   assign w_frac = i_a[MAN_W-1:0];
   assign o_sign = i_a[EXP_W+MAN_W];

   always_comb begin
      o_cls = NORM;
      if (w_exp == '0) begin
         o_cls = (w_frac == '0) ? ZERO : DENORM;
      end else if (&w_exp) begin
         if (w_frac == '0)          o_cls = INF;
         else if (w_frac[MAN_W-1])  o_cls = QNAN;
         else                       o_cls = SNAN;
      end
   end

endmodule

// File: rtl/fp_sqrt_iter.sv
// Bit-serial RNE square root: MAN_W+4 cycles accept-to-valid (specials 1), one op in flight,
// result held while out_ready is low. Define FP_SQRT_FLAGS_EN for out_flags {invalid, inexact}.
module fp_sqrt_iter
   import fp_pkg::*;
#(
   parameter int EXP_W = FP_EXP_W,
   parameter int MAN_W = FP_MAN_W
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [EXP_W+MAN_W:0] in_a,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [EXP_W+MAN_W:0] out_result
`ifdef FP_SQRT_FLAGS_EN
   ,
   output logic [1:0]           out_flags
`endif
);

   localparam int FW     = 1 + EXP_W + MAN_W;
   localparam int BIAS   = 2**(EXP_W-1) - 1;
   localparam int ROOT_W = MAN_W + 2;
   localparam int REM_W  = ROOT_W + 2;
   localparam int RAD_W  = 2 * ROOT_W;
   localparam int CNT_W  = $clog2(ROOT_W);
   localparam logic [63:0]   NAN_FULL  = fp_qnan(EXP_W, MAN_W);
   localparam logic [FW-1:0] CANON_NAN = NAN_FULL[FW-1:0];

   sqrt_state_e       r_state, w_state_nxt;
   fp_class_e         w_cls;
   logic              w_sign, w_accept, w_special;
   logic [RAD_W-1:0]  r_rad;
   logic [REM_W-1:0]  r_rem;
   logic [ROOT_W-1:0] r_root;
   logic [CNT_W-1:0]  r_cnt;
   logic [EXP_W-1:0]  r_exp;
   logic [FW-1:0]     r_result;

   logic signed [EXP_W:0] w_e;
   logic [ROOT_W-1:0]     w_rad_hi;
   logic [EXP_W-1:0]      w_res_exp;
   logic [REM_W-1:0]      w_rem_sh, w_rem_nxt, w_rem_fix;
   logic                  w_sticky, w_guard, w_round_up;
   logic [MAN_W+1:0]      w_man_rnd;
   logic [FW-1:0]         w_rnd_res, w_spec_res;

   fp_classify #(.EXP_W(EXP_W), .MAN_W(MAN_W)) u_classify (
      .i_a   (in_a),
      .o_cls (w_cls),
      .o_sign(w_sign)
   );

   assign w_accept  = in_valid & in_ready;
   assign w_special = (w_cls != NORM) | w_sign;

   // Odd exponents double the significand so the halved exponent is exact;
   // e >>> 1 already floors, so it equals (e-1)/2 in the odd case.
   always_comb begin
      w_e       = {1'b0, in_a[MAN_W +: EXP_W]} - (EXP_W+1)'(BIAS);
      w_rad_hi  = w_e[0] ? {1'b1, in_a[MAN_W-1:0], 1'b0} : {2'b01, in_a[MAN_W-1:0]};
      w_res_exp = w_e[EXP_W:1] + EXP_W'(BIAS);
   end

   always_comb begin
      w_rem_sh = {r_rem[REM_W-3:0], r_rad[RAD_W-1 -: 2]};
      if (!r_rem[REM_W-1]) w_rem_nxt = w_rem_sh - {r_root, 2'b01};
      else                 w_rem_nxt = w_rem_sh + {r_root, 2'b11};
   end

   // A negative non-restoring remainder must be corrected before the zero test.
   always_comb begin
      w_rem_fix  = r_rem[REM_W-1] ? (r_rem + {1'b0, r_root, 1'b1}) : r_rem;
      w_sticky   = |w_rem_fix;
      w_guard    = r_root[0];
      w_round_up = w_guard & (w_sticky | r_root[1]);
      w_man_rnd  = {1'b0, r_root[ROOT_W-1:1]} + {{(MAN_W+1){1'b0}}, w_round_up};
      if (w_man_rnd[MAN_W+1]) w_rnd_res = {1'b0, r_exp + EXP_W'(1), {MAN_W{1'b0}}};
      else                    w_rnd_res = {1'b0, r_exp, w_man_rnd[MAN_W-1:0]};
   end

   always_comb begin
      w_spec_res = CANON_NAN;
      case (w_cls)
         ZERO, DENORM: w_spec_res = {w_sign, {(FW-1){1'b0}}};
         INF:          if (!w_sign) w_spec_res = {1'b0, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
         default:      w_spec_res = CANON_NAN;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= IDLE;
      else        r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         IDLE:    if (in_valid) w_state_nxt = w_special ? DONE : CALC;
         CALC:    if (r_cnt == '0) w_state_nxt = ROUND;
         ROUND:   w_state_nxt = DONE;
         DONE:    if (out_ready) w_state_nxt = IDLE;
         default: w_state_nxt = IDLE;
      endcase
   end

   always_comb begin
      in_ready  = (r_state == IDLE);
      out_valid = (r_state == DONE);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_rad    <= '0;
         r_rem    <= '0;
         r_root   <= '0;
         r_cnt    <= '0;
         r_exp    <= '0;
         r_result <= '0;
      end else begin
         case (r_state)
            IDLE: if (w_accept) begin
               if (w_special) begin
                  r_result <= w_spec_res;
               end else begin
                  r_rad  <= {w_rad_hi, {ROOT_W{1'b0}}};
                  r_rem  <= '0;
                  r_root <= '0;
                  r_cnt  <= CNT_W'(MAN_W + 1);
                  r_exp  <= w_res_exp;
               end
            end
            CALC: begin
               r_rem  <= w_rem_nxt;
               r_root <= {r_root[ROOT_W-2:0], ~w_rem_nxt[REM_W-1]};
               r_rad  <= r_rad << 2;
               r_cnt  <= r_cnt - 1'b1;
            end
            ROUND: r_result <= w_rnd_res;
            default: ;
         endcase
      end
   end

   assign out_result = r_result;

`ifdef FP_SQRT_FLAGS_EN
   logic [1:0] r_flags;
   logic       w_spec_inv;

   // Negative nonzero operands (denormals count as zero) and signalling NaNs.
   always_comb begin
      w_spec_inv = 1'b0;
      case (w_cls)
         NORM, INF: w_spec_inv = w_sign;
         SNAN:      w_spec_inv = 1'b1;
         default:   w_spec_inv = 1'b0;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_flags <= 2'b00;
      end else if (r_state == IDLE && w_accept && w_special) begin
         r_flags <= {w_spec_inv, 1'b0};
      end else if (r_state == ROUND) begin
         r_flags <= {1'b0, w_guard | w_sticky};
      end
   end

   assign out_flags = r_flags;
`endif

endmodule
